fsub_4_seq: RTL and testbench

- Bit-serial multi-cycle subtractor computing diff = a - b - bin over WIDTH bits, LSB first, one bit per clock.
- It is the inverse-direction counterpart of the team's parallel ripple-carry adder, and shares the same operand/carry conventions.
- It sits on the arithmetic datapath where area matters more than latency.
- A start/busy/done handshake sequences operand capture and result delivery.

---
 rtl/fsub_pkg.sv | 13 +
 rtl/fsub_4_seq_fsub.sv | 14 +
 rtl/fsub_4_seq.sv | 146 ++++++++++++++
 tb/tb_fsub_4_seq.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fsub_pkg.sv
// Shared types and constants for the bit-serial subtractor slice.
// State encoding and default operand width used by fsub_4_seq.
package fsub_pkg;

    localparam int FSUB_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/fsub_4_seq_fsub.sv
// 1-bit full subtractor cell (a - b - bin), mirror of the full adder cell.
// Used as the single serial datapath stage of fsub_4_seq.
module fsub (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic diff_o,
    output logic bout_o
);

    assign diff_o = a_i ^ b_i ^ bin_i;
    assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/fsub_4_seq.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock.
// Optional signed-overflow output enabled by defining FSUB_4_SEQ_OVF_EN.
module fsub_4_seq
    import fsub_pkg::*;
#(
    parameter int WIDTH = FSUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef FSUB_4_SEQ_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               br_q, br_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bout_q, bout_d;
    logic [WIDTH-1:0]   resShift;
    logic               bitDiff;
    logic               bitBout;
    logic               lastBit;
`ifdef FSUB_4_SEQ_OVF_EN
    logic               aMsb_q, aMsb_d;
    logic               bMsb_q, bMsb_d;
    logic               ovf_q, ovf_d;
`endif

    fsub u_stage (
        .a_i    (a_q[0]),
        .b_i    (b_q[0]),
        .bin_i  (br_q),
        .diff_o (bitDiff),
        .bout_o (bitBout)
    );

    assign lastBit = (cnt_q == CNT_W'(WIDTH - 1));

    // Result fills from the MSB end so the first (LSB) bit ends at position 0.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        br_d     = br_q;
        res_d    = res_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        resShift = res_q >> 1;
        resShift[WIDTH-1] = bitDiff;
`ifdef FSUB_4_SEQ_OVF_EN
        aMsb_d   = aMsb_q;
        bMsb_d   = bMsb_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = BUSY;
`ifdef FSUB_4_SEQ_OVF_EN
                    aMsb_d  = a[WIDTH-1];
                    bMsb_d  = b[WIDTH-1];
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = bitBout;
                res_d = resShift;
                cnt_d = cnt_q + CNT_W'(1);
                if (lastBit) begin
                    diff_d  = resShift;
                    bout_d  = bitBout;
                    state_d = DONE;
`ifdef FSUB_4_SEQ_OVF_EN
                    ovf_d   = (aMsb_q ^ bMsb_q) & (bitDiff ^ aMsb_q);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            res_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef FSUB_4_SEQ_OVF_EN
            aMsb_q  <= 1'b0;
            bMsb_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
`ifdef FSUB_4_SEQ_OVF_EN
            aMsb_q  <= aMsb_d;
            bMsb_q  <= bMsb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == BUSY);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;
`ifdef FSUB_4_SEQ_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_fsub_4_seq.sv
// Directed self-checking bench for fsub_4_seq (ovf checked when FSUB_4_SEQ_OVF_EN is defined).
module tb_fsub_4_seq;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef FSUB_4_SEQ_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;
    logic [W-1:0] prevDiff;
    logic         prevBout;

    fsub_4_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef FSUB_4_SEQ_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOvf(input string tag, input logic expOvf);
`ifdef FSUB_4_SEQ_OVF_EN
        checkOutput(tag, {7'd0, ovf}, {7'd0, expOvf});
`endif
    endtask

    // One full operation with start pulsed for a single cycle.
    task automatic applyStimulus(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic binv, input logic [W-1:0] expD, input logic expB,
                                 input logic expOvf);
        a = av; b = bv; bin = binv; start = 1'b1;
        tick();
        start = 1'b0; a = ~av; b = ~bv; bin = ~binv;
        checkOutput({tag, "_busy0"}, {7'd0, busy}, 8'd1);
        checkOutput({tag, "_done0"}, {7'd0, done}, 8'd0);
        for (int i = 1; i < W; i++) begin
            tick();
            checkOutput({tag, "_busyMid"}, {7'd0, busy}, 8'd1);
            checkOutput({tag, "_diffHeld"}, {4'd0, diff}, {4'd0, prevDiff});
            checkOutput({tag, "_boutHeld"}, {7'd0, bout}, {7'd0, prevBout});
        end
        tick();
        checkOutput({tag, "_done"}, {7'd0, done}, 8'd1);
        checkOutput({tag, "_busyOff"}, {7'd0, busy}, 8'd0);
        checkOutput({tag, "_diff"}, {4'd0, diff}, {4'd0, expD});
        checkOutput({tag, "_bout"}, {7'd0, bout}, {7'd0, expB});
        checkOvf({tag, "_ovf"}, expOvf);
        tick();
        checkOutput({tag, "_doneDrop"}, {7'd0, done}, 8'd0);
        checkOutput({tag, "_idleBusy"}, {7'd0, busy}, 8'd0);
        checkOutput({tag, "_diffKeep"}, {4'd0, diff}, {4'd0, expD});
        prevDiff = expD;
        prevBout = expB;
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; a = 4'd9; b = 4'd3; bin = 1'b0;
        prevDiff = '0; prevBout = 1'b0;

        // Reset, with start asserted alongside it.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy", {7'd0, busy}, 8'd0);
        checkOutput("rst_done", {7'd0, done}, 8'd0);
        checkOutput("rst_diff", {4'd0, diff}, 8'd0);
        checkOutput("rst_bout", {7'd0, bout}, 8'd0);
        checkOvf("rst_ovf", 1'b0);
        rst = 1'b0; start = 1'b0;
        tick();
        checkOutput("idle_busy", {7'd0, busy}, 8'd0);

        // Basic operations.
        applyStimulus("op9m3", 4'd9, 4'd3, 1'b0, 4'd6, 1'b0, 1'b1);
        applyStimulus("op3m9", 4'd3, 4'd9, 1'b0, 4'hA, 1'b1, 1'b1);
        applyStimulus("op0m0b", 4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b0);

        // Start while busy must be ignored.
        a = 4'd7; b = 4'd2; bin = 1'b0; start = 1'b1;
        tick();
        a = 4'd15; b = 4'd0; bin = 1'b1;
        checkOutput("ign_busy0", {7'd0, busy}, 8'd1);
        tick();
        tick();
        start = 1'b0;
        checkOutput("ign_busy2", {7'd0, busy}, 8'd1);
        tick();
        checkOutput("ign_busy3", {7'd0, busy}, 8'd1);
        checkOutput("ign_diffHeld", {4'd0, diff}, 8'h0F);
        tick();
        checkOutput("ign_done", {7'd0, done}, 8'd1);
        checkOutput("ign_diff", {4'd0, diff}, 8'd5);
        checkOutput("ign_bout", {7'd0, bout}, 8'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("ign_noDone", {7'd0, done}, 8'd0);
            checkOutput("ign_noBusy", {7'd0, busy}, 8'd0);
        end

        // Back-to-back with start held: 5-1 then 2-4.
        a = 4'd5; b = 4'd1; bin = 1'b0; start = 1'b1;
        tick();
        a = 4'd2; b = 4'd4; bin = 1'b0;
        checkOutput("b2b_busyA", {7'd0, busy}, 8'd1);
        repeat (3) tick();
        checkOutput("b2b_preDoneA", {7'd0, done}, 8'd0);
        tick();
        checkOutput("b2b_doneA", {7'd0, done}, 8'd1);
        checkOutput("b2b_diffA", {4'd0, diff}, 8'd4);
        checkOutput("b2b_boutA", {7'd0, bout}, 8'd0);
        tick();
        start = 1'b0;
        checkOutput("b2b_busyB", {7'd0, busy}, 8'd1);
        checkOutput("b2b_doneOffB", {7'd0, done}, 8'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("b2b_diffStable", {4'd0, diff}, 8'd4);
            checkOutput("b2b_noDone", {7'd0, done}, 8'd0);
        end
        tick();
        checkOutput("b2b_doneB", {7'd0, done}, 8'd1);
        checkOutput("b2b_diffB", {4'd0, diff}, 8'h0E);
        checkOutput("b2b_boutB", {7'd0, bout}, 8'd1);
        tick();
        checkOutput("b2b_idle", {7'd0, done}, 8'd0);

        // Reset two cycles into an operation.
        a = 4'd6; b = 4'd1; bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        checkOutput("abort_busy", {7'd0, busy}, 8'd0);
        checkOutput("abort_done", {7'd0, done}, 8'd0);
        checkOutput("abort_diff", {4'd0, diff}, 8'd0);
        checkOutput("abort_bout", {7'd0, bout}, 8'd0);
        checkOvf("abort_ovf", 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("abort_staysIdle", {7'd0, busy | done}, 8'd0);
        end
        prevDiff = '0; prevBout = 1'b0;
        applyStimulus("op6m1", 4'd6, 4'd1, 1'b0, 4'd5, 1'b0, 1'b0);

        // Signed-overflow cases.
        applyStimulus("op8m1", 4'd8, 4'd1, 1'b0, 4'd7, 1'b0, 1'b1);
        applyStimulus("op4m2", 4'd4, 4'd2, 1'b0, 4'd2, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
